// File: rtl/arbiter_pkg.sv
// Shared definitions for the two-requester arbiter.
//
// Contents:
//   PRIO_W_DEF   default width of each requester priority input
//   arb_state_t  arbiter states (IDLE, GRANT_A, GRANT_B); 2'b11 is unused
//   grant_a_of / grant_b_of  decode a state into its grant lines
//
// Optional feature macro used by the files that import this package:
//   ARB_FAIR_TIE_EN  equal-priority ties go to the requester not granted most recently
package arbiter_pkg;

  localparam int PRIO_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } arb_state_t;

  // Grant lines are a pure function of the state, so the registered outputs
  // can be loaded from the next state and always agree with the state register.
  function automatic logic grant_a_of(input arb_state_t s);
    return (s == GRANT_A);
  endfunction

  function automatic logic grant_b_of(input arb_state_t s);
    return (s == GRANT_B);
  endfunction

endpackage

// File: rtl/arbiter_pick.sv
// Combinational arbitration decision taken only when the resource is free.
//
// Ports:
//   ra, rb     requests from A and B
//   PA, PB     unsigned priorities; larger value wins
//   last_b     (ARB_FAIR_TIE_EN only) 1 when B was granted most recently
//   pick_a     A should be granted
//   pick_b     B should be granted
// pick_a and pick_b are never both 1; both are 0 when nobody requests.
//
// Macro ARB_FAIR_TIE_EN: when defined, equal priorities are resolved in favour
// of the requester that did not win last time; otherwise A wins every tie.
module arbiter_pick
  import arbiter_pkg::*;
#(
  parameter int PRIO_W = PRIO_W_DEF
) (
  input  logic              ra,
  input  logic              rb,
  input  logic [PRIO_W-1:0] PA,
  input  logic [PRIO_W-1:0] PB,
`ifdef ARB_FAIR_TIE_EN
  input  logic              last_b,
`endif
  output logic              pick_a,
  output logic              pick_b
);

  logic tie_to_a;

  // Tie-break source: rotate on the last winner, or fixed preference for A.
`ifdef ARB_FAIR_TIE_EN
  assign tie_to_a = last_b;
`else
  assign tie_to_a = 1'b1;
`endif

  // A wins when it is alone, strictly higher, or equal and favoured by the
  // tie-break; B takes whatever A did not claim.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (ra && !rb) begin
      pick_a = 1'b1;
    end else if (rb && !ra) begin
      pick_b = 1'b1;
    end else if (ra && rb) begin
      if (PA > PB) begin
        pick_a = 1'b1;
      end else if (PB > PA) begin
        pick_b = 1'b1;
      end else if (tie_to_a) begin
        pick_a = 1'b1;
      end else begin
        pick_b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_2req.sv
// Two-requester, single-resource, non-preemptive arbiter.
// A grant is held for as long as its owner keeps requesting; priorities only
// matter when arbitrating from IDLE. Grants are registered (one clock latency).
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (0 = reset)
//   ra, rb   level requests from A and B
//   PA, PB   priorities of A and B (larger wins), sampled only from IDLE
//   ga, gb   registered grants to A and B, never both 1
//
// Macro ARB_FAIR_TIE_EN: when defined, a last-winner register (reset to B)
// breaks equal-priority ties in favour of the requester not granted most
// recently; when undefined A always wins ties and the register is absent.
module arbiter_2req
  import arbiter_pkg::*;
#(
  parameter int PRIO_W = PRIO_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ra,
  input  logic              rb,
  input  logic [PRIO_W-1:0] PA,
  input  logic [PRIO_W-1:0] PB,
  output logic              ga,
  output logic              gb
);

  arb_state_t state;
  arb_state_t state_next;
  logic       pick_a;
  logic       pick_b;

`ifdef ARB_FAIR_TIE_EN
  logic last_b;
`endif

  arbiter_pick #(
    .PRIO_W (PRIO_W)
  ) u_pick (
    .ra     (ra),
    .rb     (rb),
    .PA     (PA),
    .PB     (PB),
`ifdef ARB_FAIR_TIE_EN
    .last_b (last_b),
`endif
    .pick_a (pick_a),
    .pick_b (pick_b)
  );

  // Next state. An owner keeps the resource while it requests; when it lets
  // go, a waiting requester takes over directly without passing through IDLE.
  // The unused encoding falls back to IDLE.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (pick_a) begin
          state_next = GRANT_A;
        end else if (pick_b) begin
          state_next = GRANT_B;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT_A: begin
        if (ra) begin
          state_next = GRANT_A;
        end else if (rb) begin
          state_next = GRANT_B;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT_B: begin
        if (rb) begin
          state_next = GRANT_B;
        end else if (ra) begin
          state_next = GRANT_A;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and grant registers. Grants are loaded from the next state so they
  // change on the same edge as the state, making handoffs gapless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ga    <= 1'b0;
      gb    <= 1'b0;
`ifdef ARB_FAIR_TIE_EN
      last_b <= 1'b1;
`endif
    end else begin
      state <= state_next;
      ga    <= grant_a_of(state_next);
      gb    <= grant_b_of(state_next);
`ifdef ARB_FAIR_TIE_EN
      if (state_next == GRANT_A) begin
        last_b <= 1'b0;
      end else if (state_next == GRANT_B) begin
        last_b <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_arbiter_2req.sv
// Self-checking bench for arbiter_2req: directed scenarios followed by a
// randomized run, all checked against a resource-ownership model.
module tb_arbiter_2req;

  logic       clk;
  logic       rst;
  logic       ra;
  logic       rb;
  logic [1:0] PA;
  logic [1:0] PB;
  logic       ga;
  logic       gb;

  int checks;
  int failures;

  // Model: who owns the resource (0 nobody, 1 A, 2 B) and who won last.
  int   owner;
  logic model_last_b;

  arbiter_2req #(
    .PRIO_W (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ra  (ra),
    .rb  (rb),
    .PA  (PA),
    .PB  (PB),
    .ga  (ga),
    .gb  (gb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int next_owner(input int cur, input logic a, input logic b,
                                    input int pa, input int pb, input logic tie_a);
    if (cur == 1) return a ? 1 : (b ? 2 : 0);
    if (cur == 2) return b ? 2 : (a ? 1 : 0);
    if (a && !b) return 1;
    if (b && !a) return 2;
    if (!a && !b) return 0;
    if (pa > pb) return 1;
    if (pb > pa) return 2;
    return tie_a ? 1 : 2;
  endfunction

  function automatic logic [1:0] grants_of(input int o);
    return {o == 1, o == 2};
  endfunction

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic step(input logic a, input logic b, input logic [1:0] pa, input logic [1:0] pb);
    logic tie_a;
    ra = a;
    rb = b;
    PA = pa;
    PB = pb;
    @(posedge clk);
    #1;
`ifdef ARB_FAIR_TIE_EN
    tie_a = model_last_b;
`else
    tie_a = 1'b1;
`endif
    owner = next_owner(owner, a, b, int'(pa), int'(pb), tie_a);
    if (owner == 1) model_last_b = 1'b0;
    if (owner == 2) model_last_b = 1'b1;
  endtask

  task automatic model_reset();
    owner        = 0;
    model_last_b = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ra  = 1'b0;
    rb  = 1'b0;
    PA  = 2'd0;
    PB  = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ga, gb} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_held got=%b%b want=00", ga, gb);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 2'd0, 2'd0);
    checks++;
    if ({ga, gb} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_release got=%b%b want=00", ga, gb);
    end
  endtask

  task automatic test_single();
    step(1'b1, 1'b0, 2'd0, 2'd0);
    checks++;
    if ({ga, gb} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL single_req_a got=%b%b want=10", ga, gb);
    end
  endtask

  task automatic test_hold();
    step(1'b1, 1'b1, 2'd0, 2'd3);
    checks++;
    if ({ga, gb} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL hold_vs_b got=%b%b want=10", ga, gb);
    end
    step(1'b1, 1'b0, 2'd0, 2'd3);
    checks++;
    if ({ga, gb} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL hold_after got=%b%b want=10", ga, gb);
    end
  endtask

  task automatic test_handoff();
    step(1'b0, 1'b1, 2'd0, 2'd0);
    checks++;
    if ({ga, gb} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL handoff_a_to_b got=%b%b want=01", ga, gb);
    end
  endtask

  task automatic test_rerequest();
    step(1'b1, 1'b1, 2'd3, 2'd0);
    checks++;
    if ({ga, gb} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rereq_b_holds got=%b%b want=01", ga, gb);
    end
    step(1'b1, 1'b0, 2'd3, 2'd0);
    checks++;
    if ({ga, gb} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL rereq_handoff got=%b%b want=10", ga, gb);
    end
    step(1'b0, 1'b0, 2'd0, 2'd0);
    checks++;
    if ({ga, gb} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL rereq_idle got=%b%b want=00", ga, gb);
    end
  endtask

  task automatic test_priority();
    logic [1:0] pa_tab [3];
    logic [1:0] pb_tab [3];
    logic [1:0] want;
    pa_tab = '{2'd0, 2'd3, 2'd0};
    pb_tab = '{2'd3, 2'd0, 2'd0};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, pa_tab[i], pb_tab[i]);
      if (pa_tab[i] > pb_tab[i]) want = 2'b10;
      else if (pb_tab[i] > pa_tab[i]) want = 2'b01;
      else want = grants_of(owner);
`ifndef ARB_FAIR_TIE_EN
      if (pa_tab[i] == pb_tab[i]) want = 2'b10;
`endif
      checks++;
      if ({ga, gb} !== want) begin
        failures++;
        $display("[TB] FAIL priority_%0d PA=%0d PB=%0d got=%b%b want=%b",
                 i, pa_tab[i], pb_tab[i], ga, gb, want);
      end
      step(1'b0, 1'b0, pa_tab[i], pb_tab[i]);
      checks++;
      if ({ga, gb} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL priority_release_%0d got=%b%b want=00", i, ga, gb);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    step(1'b1, 1'b0, 2'd0, 2'd0);
    checks++;
    if ({ga, gb} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL midreset_setup got=%b%b want=10", ga, gb);
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({ga, gb} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL midreset_async got=%b%b want=00", ga, gb);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 2'd0, 2'd0);
    checks++;
    if ({ga, gb} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL midreset_rearb got=%b%b want=01", ga, gb);
    end
  endtask

  task automatic test_random();
    logic a;
    logic b;
    a = 1'b0;
    b = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({ga, gb} !== 2'b00) begin
          failures++;
          $display("[TB] FAIL random_reset iter=%0d got=%b%b want=00", i, ga, gb);
        end
        @(negedge clk);
        rst = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      step(a, b, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      checks++;
      if ({ga, gb} !== grants_of(owner)) begin
        failures++;
        $display("[TB] FAIL random iter=%0d ra=%b rb=%b PA=%0d PB=%0d got=%b%b want=%b",
                 i, ra, rb, PA, PB, ga, gb, grants_of(owner));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_hold();
    test_handoff();
    test_rerequest();
    test_priority();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
